data_mem_ctrl: RTL and testbench
================================

// Module: data_mem_ctrl
// PURPOSE
//   Memory-side responder for the CPU data bus (addr_bus / data_bus / mem_read / mem_wrt).
//   Holds a word-addressed data RAM and serves one load or store at a time.
//   Inserts a programmable number of wait states, then signals completion with a one-cycle
//   mem_ready pulse. Sits between the CPU core and the backing data store.
// PARAMETERS
//   DATA_W       32  data bus width, in bits
//   ADDR_W       32  address bus width, in bits (byte address)
//   DEPTH_LOG2   10  log2 of the RAM depth, in words (1024 x 32 by default)
//   WAIT_CYCLES   2  wait states between request sampling and completion; 0 is legal
// PORTS
//   clk          in   1        system clock; all state updates on the rising edge
//   rst          in   1        synchronous reset, active-high
//   addr_bus     in   ADDR_W   byte address from the CPU
//   data_bus_in  in   DATA_W   store data from the CPU (the CPU's data_bus_out)
//   mem_read     in   1        load request
//   mem_wrt      in   1        store request
//   data_bus_out out  DATA_W   load data to the CPU (the CPU's data_bus_in)
//   mem_ready    out  1        access complete; one-cycle pulse
// BEHAVIOUR
//   - Reset: one clock, rst=1, synchronous and active-high. Result: state=IDLE,
//     mem_ready=0, data_bus_out=0, wait counter=0. RAM contents are not cleared.
//   - FSM states: IDLE, BUSY, DONE.
//   - IDLE, with mem_read|mem_wrt high at the edge:
//       latch addr_bus, data_bus_in and the op.
//       Go to BUSY with cnt=WAIT_CYCLES, or straight to DONE if WAIT_CYCLES==0.
//       With no request, stay in IDLE.
//   - BUSY: cnt decrements each cycle. At the edge where cnt==1, the access executes and the
//     FSM moves to DONE.
//   - Access execution: a store writes the latched data to RAM; a load registers the RAM word
//     into data_bus_out.
//   - DONE: mem_ready=1 for exactly this cycle; unconditional return to IDLE.
//   - Latency: request sampled at edge N -> mem_ready high during cycle N+WAIT_CYCLES+1.
//   - Bus inputs are ignored in BUSY and DONE; the latched copy is authoritative.
//   - A request still asserted on the first IDLE cycle after DONE starts a new access.
//     The requester must drop mem_read/mem_wrt on the cycle mem_ready is seen.
//   - mem_read and mem_wrt both high: treated as a store; no load is performed.
//   - data_bus_out changes only when a load executes (or on reset). It holds its value
//     across stores and idle cycles.
//   - Word index = addr_bus[DEPTH_LOG2+1:2]. addr_bus[1:0] and the bits above the index
//     are ignored, so addresses alias modulo 4*2^DEPTH_LOG2 bytes.
//   - Reset mid-access (BUSY or DONE):
//       the access is abandoned and no mem_ready is produced;
//       a store whose execution edge has not yet occurred is not committed.
//   - Reset and execution on the same edge: reset wins and the RAM is not written.
// CONFIGURATION
//   DMEM_ERR_EN defined:
//     - Adds output port mem_err (1 bit, reset 0).
//     - An access is flagged if addr_bus[1:0]!=0 (misaligned) or any address bit above
//       DEPTH_LOG2+1 is set (out of range). This check uses the latched address.
//     - A flagged store does not write the RAM.
//     - A flagged load drives data_bus_out=0.
//     - mem_err pulses high together with mem_ready in DONE. Timing is unchanged.
//   DMEM_ERR_EN undefined: no mem_err port; no checking; aliasing rules above apply.
// TESTING  (defaults: WAIT_CYCLES=2, DEPTH_LOG2=10)
//   1. Reset, then store 0xDEADBEEF @0x10, then load @0x10
//      -> each access: mem_ready high 3 cycles after the request edge;
//         load returns data_bus_out=0xDEADBEEF.
//   2. mem_read=mem_wrt=1, addr 0x20, data 0x12345678 with data_bus_out previously 0xDEADBEEF
//      -> data_bus_out stays 0xDEADBEEF; a later load @0x20 returns 0x12345678.
//   3. Store 0xA5A5A5A5 @0x1000, then load @0x0000
//      -> returns 0xA5A5A5A5 (aliasing; macro off).
//   4. @0x30 holds 0x11111111; store 0x22222222 @0x30; pulse rst in the first BUSY cycle
//      -> no mem_ready; a later load @0x30 returns 0x11111111.
//   5. Load @0x40 (holds 0xCAFEF00D); change addr_bus to 0x44 and drop mem_read while BUSY
//      -> mem_ready still pulses; data_bus_out=0xCAFEF00D.
//   6. DMEM_ERR_EN defined: load @0x02, then store 0xFFFFFFFF @0x00004000
//      -> both: mem_err=1 with mem_ready; load returns data_bus_out=0;
//         a load @0x0 then returns its prior contents.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Word-addressed data RAM responder for the CPU data bus with programmable wait states.
// Optional address checking and the mem_err output are enabled by defining DMEM_ERR_EN.
module data_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_bus,
    input  logic [DATA_W-1:0] data_bus_in,
    input  logic              mem_read,
    input  logic              mem_wrt,
    output logic [DATA_W-1:0] data_bus_out,
    output logic              mem_ready
`ifdef DMEM_ERR_EN
    ,
    output logic              mem_err
`endif
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  wr_q, wr_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic [DATA_W-1:0]     mem_q [DEPTH];

    logic                  req;
    logic                  exec;
    logic                  ex_wr;
    logic                  ex_err;
    logic [DEPTH_LOG2-1:0] ex_idx;
    logic [DATA_W-1:0]     ex_data;

    assign req = mem_read | mem_wrt;

    // With zero wait states the access executes on the sampling edge, so the
    // execution operands come straight from the bus while IDLE.
    assign exec = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                  ((state_q == BUSY) && (cnt_q == CNT_W'(1)));
    assign ex_wr   = (state_q == IDLE) ? mem_wrt     : wr_q;
    assign ex_data = (state_q == IDLE) ? data_bus_in : wdata_q;

`ifdef DMEM_ERR_EN
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] ex_addr;
    logic              err_q, err_d;

    assign ex_addr = (state_q == IDLE) ? addr_bus : addr_q;
    assign ex_idx  = ex_addr[DEPTH_LOG2+1:2];
    assign ex_err  = (|ex_addr[1:0]) | (|ex_addr[ADDR_W-1:DEPTH_LOG2+2]);
    assign err_d   = exec ? ex_err : err_q;
    assign mem_err = (state_q == DONE) & err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if ((state_q == IDLE) && req) begin
                addr_q <= addr_bus;
            end
            err_q <= err_d;
        end
    end
`else
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  unused_addr_bits;

    // Bits outside the word index are deliberately dropped: addresses alias.
    assign unused_addr_bits = ^{addr_bus[ADDR_W-1:DEPTH_LOG2+2], addr_bus[1:0]};
    assign ex_idx = (state_q == IDLE) ? addr_bus[DEPTH_LOG2+1:2] : idx_q;
    assign ex_err = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
        end else if ((state_q == IDLE) && req) begin
            idx_q <= addr_bus[DEPTH_LOG2+1:2];
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    wdata_d = data_bus_in;
                    wr_d    = mem_wrt;
                    if (WAIT_CYCLES == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (exec && !ex_wr) begin
            rdata_d = ex_err ? '0 : mem_q[ex_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
        end
    end

    // RAM is never cleared; reset only suppresses a write on its edge.
    always_ff @(posedge clk) begin
        if (!rst && exec && ex_wr && !ex_err) begin
            mem_q[ex_idx] <= ex_data;
        end
    end

    assign data_bus_out = rdata_q;
    assign mem_ready    = (state_q == DONE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (default parameters).
// Defining DMEM_ERR_EN also exercises the address-error checks.
module tb_data_mem_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] addr_bus;
    logic [31:0] data_bus_in;
    logic        mem_read;
    logic        mem_wrt;
    logic [31:0] data_bus_out;
    logic        mem_ready;
    logic        mem_err;

    int errors;
    int checks;

    data_mem_ctrl #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .DEPTH_LOG2  (10),
        .WAIT_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_bus     (addr_bus),
        .data_bus_in  (data_bus_in),
        .mem_read     (mem_read),
        .mem_wrt      (mem_wrt),
        .data_bus_out (data_bus_out),
        .mem_ready    (mem_ready)
`ifdef DMEM_ERR_EN
        ,
        .mem_err      (mem_err)
`endif
    );

`ifndef DMEM_ERR_EN
    assign mem_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request; lat counts rising edges from the request edge to the
    // edge after which mem_ready is first seen (20 means it never came).
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, output int lat,
                          output logic pulse_ok, output logic err_seen);
        @(negedge clk);
        mem_read    = rd;
        mem_wrt     = wr;
        addr_bus    = a;
        data_bus_in = d;
        @(posedge clk);
        lat = 1;
        #1;
        mem_read = 1'b0;
        mem_wrt  = 1'b0;
        err_seen = 1'b0;
        pulse_ok = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            if (mem_ready) break;
            @(posedge clk);
            lat++;
        end
        if (lat < 20) begin
            err_seen = mem_err;
            @(negedge clk);
            pulse_ok = !mem_ready;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_read = 1'b0;
        mem_wrt = 1'b0;
        addr_bus = '0;
        data_bus_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", mem_ready);
        end
        checks++;
        if (data_bus_out !== 32'h0) begin
            errors++;
            $display("FAIL reset_dout: got %h want 00000000", data_bus_out);
        end
    endtask

    task automatic test_store_load();
        int lat; logic pok; logic e;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, lat, pok, e);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL store_latency: got %0d want 3", lat);
        end
        checks++;
        if (pok !== 1'b1) begin
            errors++;
            $display("FAIL store_pulse: got %b want 1", pok);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, lat, pok, e);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL load_latency: got %0d want 3", lat);
        end
        checks++;
        if (pok !== 1'b1) begin
            errors++;
            $display("FAIL load_pulse: got %b want 1", pok);
        end
        checks++;
        if (data_bus_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_data: got %h want deadbeef", data_bus_out);
        end
    endtask

    task automatic test_both_ops();
        int lat; logic pok; logic e;
        access(1'b1, 1'b1, 32'h20, 32'h12345678, lat, pok, e);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL both_latency: got %0d want 3", lat);
        end
        checks++;
        if (data_bus_out !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL both_dout_hold: got %h want deadbeef", data_bus_out);
        end
        access(1'b1, 1'b0, 32'h20, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'h12345678) begin
            errors++;
            $display("FAIL both_stored: got %h want 12345678", data_bus_out);
        end
    endtask

    task automatic test_alias();
        int lat; logic pok; logic e;
        access(1'b0, 1'b1, 32'h1000, 32'hA5A5A5A5, lat, pok, e);
        access(1'b1, 1'b0, 32'h0000, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL alias_load: got %h want a5a5a5a5", data_bus_out);
        end
        access(1'b1, 1'b0, 32'h0000_1003, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL alias_low_bits: got %h want a5a5a5a5", data_bus_out);
        end
    endtask

    task automatic test_reset_mid_access();
        int lat; logic pok; logic e; int seen;
        access(1'b0, 1'b1, 32'h30, 32'h11111111, lat, pok, e);
        @(negedge clk);
        mem_wrt     = 1'b1;
        addr_bus    = 32'h30;
        data_bus_in = 32'h22222222;
        @(posedge clk);
        #1 mem_wrt = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (mem_ready) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_ready: got %0d pulses want 0", seen);
        end
        checks++;
        if (data_bus_out !== 32'h0) begin
            errors++;
            $display("FAIL abort_dout_reset: got %h want 00000000", data_bus_out);
        end
        access(1'b1, 1'b0, 32'h30, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'h11111111) begin
            errors++;
            $display("FAIL abort_not_committed: got %h want 11111111", data_bus_out);
        end
    endtask

    task automatic test_bus_ignored();
        int lat; logic pok;
        access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, lat, pok, pok);
        access(1'b0, 1'b1, 32'h44, 32'h0BADBEEF, lat, pok, pok);
        @(negedge clk);
        mem_read = 1'b1;
        addr_bus = 32'h40;
        @(posedge clk);
        #1;
        mem_read = 1'b0;
        addr_bus = 32'h44;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (mem_ready) break;
            @(posedge clk);
            lat++;
        end
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL ignored_latency: got %0d want 3", lat);
        end
        checks++;
        if (data_bus_out !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL ignored_data: got %h want cafef00d", data_bus_out);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; logic pok; logic e;
        access(1'b0, 1'b1, 32'h50, 32'h01020304, lat, pok, e);
        access(1'b0, 1'b1, 32'h54, 32'h0A0B0C0D, lat, pok, e);
        access(1'b1, 1'b0, 32'h50, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'h01020304) begin
            errors++;
            $display("FAIL b2b_first: got %h want 01020304", data_bus_out);
        end
        access(1'b0, 1'b1, 32'h60, 32'h77777777, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'h01020304) begin
            errors++;
            $display("FAIL b2b_hold_on_store: got %h want 01020304", data_bus_out);
        end
        access(1'b1, 1'b0, 32'h54, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'h0A0B0C0D) begin
            errors++;
            $display("FAIL b2b_second: got %h want 0a0b0c0d", data_bus_out);
        end
    endtask

`ifdef DMEM_ERR_EN
    task automatic test_errors();
        int lat; logic pok; logic e;
        access(1'b0, 1'b1, 32'h0, 32'h5555AAAA, lat, pok, e);
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL err_clean_store: got %b want 0", e);
        end
        access(1'b1, 1'b0, 32'h02, 32'h0, lat, pok, e);
        checks++;
        if (e !== 1'b1 || lat !== 3) begin
            errors++;
            $display("FAIL err_misaligned: got err=%b lat=%0d want err=1 lat=3", e, lat);
        end
        checks++;
        if (data_bus_out !== 32'h0) begin
            errors++;
            $display("FAIL err_load_zero: got %h want 00000000", data_bus_out);
        end
        access(1'b0, 1'b1, 32'h0000_4000, 32'hFFFFFFFF, lat, pok, e);
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL err_range: got %b want 1", e);
        end
        access(1'b1, 1'b0, 32'h0, 32'h0, lat, pok, e);
        checks++;
        if (data_bus_out !== 32'h5555AAAA || e !== 1'b0) begin
            errors++;
            $display("FAIL err_no_write: got %h err=%b want 5555aaaa err=0", data_bus_out, e);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_store_load();
        test_both_ops();
`ifndef DMEM_ERR_EN
        test_alias();
`endif
        test_reset_mid_access();
        test_bus_ignored();
        test_back_to_back();
`ifdef DMEM_ERR_EN
        test_errors();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
